miss_entry_table: RTL
=====================

# miss_entry_table

Entry table on the icache miss path that owns the lifecycle of each miss entry: allocates the lowest free slot, issues pending entries to memory, and retires them on memory response. It produces the per-entry valid list that the free-slot finder consumes, and consumes the memory response stream that releases entries. One instance sits per SM icache, between the tag-miss logic and the L2 request port.

## Interface

Parameters:
- NUM_ENTRY, 4, number of miss entries
- ENTRY_DEPTH, 2, index width, log2(NUM_ENTRY)
- ADDR_WIDTH, 32, line address width
- WID_WIDTH, 3, warp id width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- alloc_valid_i  in  1  miss wants an entry
- alloc_ready_o  out  1  table not full
- alloc_addr_i  in  ADDR_WIDTH  miss line address
- alloc_wid_i  in  WID_WIDTH  requesting warp
- alloc_id_o  out  ENTRY_DEPTH  index granted on this handshake
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts
- mem_req_addr_o  out  ADDR_WIDTH  address of issuing entry
- mem_req_id_o  out  ENTRY_DEPTH  index of issuing entry
- mem_rsp_valid_i  in  1  memory response
- mem_rsp_id_i  in  ENTRY_DEPTH  entry being answered
- rsp_valid_o  out  1  retire pulse, one cycle
- rsp_addr_o  out  ADDR_WIDTH  retired entry address
- rsp_wid_o  out  WID_WIDTH  retired entry warp id
- valid_list_o  out  NUM_ENTRY  bit i set when entry i is not FREE
- full_o  out  1  all entries non-FREE
- empty_o  out  1  all entries FREE

## Operation

- Per-entry state: FREE, PENDING (allocated, not yet sent), ISSUED (sent, awaiting response). Each entry stores its addr and wid.
- Allocation: on alloc_valid_i & alloc_ready_o, the lowest-index FREE entry becomes PENDING. alloc_id_o is combinational and equals that index. alloc_ready_o = ~full_o, computed from registered state only.
- Issue: mem_req_valid_o = any PENDING entry or lock held. Selection is the lowest-index PENDING entry. When valid is high and ready is low, a lock register captures the index, and id/addr stay fixed until the handshake. On the handshake the entry becomes ISSUED and the lock clears.
- Retire: on mem_rsp_valid_i with entry mem_rsp_id_i ISSUED, that entry becomes FREE at the edge. At the same edge, rsp_valid_o/addr/wid register the stored values.
  - A response to a FREE or PENDING entry is ignored: no state change, no rsp_valid_o.
- Simultaneous events:
  - Allocation and retirement in one cycle use pre-edge state, so a slot freed this cycle is not grantable until the next cycle.
  - An issue handshake and a response to a different entry both take effect.
  - With alloc, issue and retire all in one cycle, all three apply.
- full_o = &valid_list_o; empty_o = ~|valid_list_o.

## Timing

- Reset (asynchronous assert, synchronous release):
  - All entries FREE, lock cleared.
  - rsp_valid_o=0, rsp_addr_o=0, rsp_wid_o=0, mem_req_valid_o=0.
  - alloc_ready_o=1, valid_list_o=0, full_o=0, empty_o=1, alloc_id_o=0.
- Reset mid-operation drops all entries with no responses emitted. Responses arriving after reset are ignored as responses to FREE entries.
- Alloc to mem_req_valid_o: 1 cycle minimum, when no lower PENDING entry or lock is active.
- Issue handshake to a later response: at least 1 cycle. A response in the same cycle as its own issue handshake is ignored.
- Response to rsp_valid_o: 1 cycle. valid_list_o bit clears in the same cycle rsp_valid_o rises.
- Throughput: one alloc, one issue and one retire per cycle.
- Once asserted, mem_req_valid_o stays high with stable id/addr until mem_req_ready_i.

## Test plan

- Reset, then 4 allocs on consecutive cycles with mem_req_ready_i=0 -> alloc_id_o 0,1,2,3; full_o=1 and alloc_ready_o=0 after the 4th; valid_list_o=4'b1111; mem_req_id_o held at 0.
- Entries 1 and 3 PENDING, ready low for 3 cycles while entry 0 is allocated -> mem_req_id_o stays 1 (lock) until the handshake, then 0, then 3.
- Entry 2 ISSUED with addr 0x1000 and wid 5; mem_rsp_id_i=2 -> next cycle rsp_valid_o=1, rsp_addr_o=0x1000, rsp_wid_o=5; valid_list_o bit2 cleared; single-cycle pulse.
- Full table; in one cycle, response frees entry 1 and alloc_valid_i=1 -> no grant that cycle; next cycle alloc_id_o=1 is granted.
- Response to PENDING entry 0 and to FREE entry 3 -> no rsp_valid_o, valid_list_o unchanged.
- 2 entries ISSUED, rst_n asserted mid-cycle -> outputs go to reset values immediately; empty_o=1; a later response to those ids produces nothing.

Source files
------------

// File: rtl/miss_entry_table.sv
// Icache miss entry table: allocates the lowest free slot, issues pending entries
// to memory in index order, and retires an entry when memory answers it.
module miss_entry_table #(
  parameter int NUM_ENTRY   = 4,
  parameter int ENTRY_DEPTH = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int WID_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0]  alloc_addr_i,
  input  logic [WID_WIDTH-1:0]   alloc_wid_i,
  output logic [ENTRY_DEPTH-1:0] alloc_id_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr_o,
  output logic [ENTRY_DEPTH-1:0] mem_req_id_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [ENTRY_DEPTH-1:0] mem_rsp_id_i,
  output logic                   rsp_valid_o,
  output logic [ADDR_WIDTH-1:0]  rsp_addr_o,
  output logic [WID_WIDTH-1:0]   rsp_wid_o,
  output logic [NUM_ENTRY-1:0]   valid_list_o,
  output logic                   full_o,
  output logic                   empty_o
);

  typedef enum logic [1:0] {E_FREE, E_PEND, E_ISSUED} entry_st_e;

  entry_st_e              st_q   [NUM_ENTRY];
  logic [ADDR_WIDTH-1:0]  addr_q [NUM_ENTRY];
  logic [WID_WIDTH-1:0]   wid_q  [NUM_ENTRY];
  logic                   lock_vld_q, lock_vld_d;
  logic [ENTRY_DEPTH-1:0] lock_id_q, lock_id_d;
  logic                   rsp_valid_q;
  logic [ADDR_WIDTH-1:0]  rsp_addr_q;
  logic [WID_WIDTH-1:0]   rsp_wid_q;

  logic                   pend_found;
  logic [ENTRY_DEPTH-1:0] free_id, pend_id;
  logic                   alloc_fire, issue_fire, retire;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    free_id      = '0;
    pend_id      = '0;
    pend_found   = 1'b0;
    valid_list_o = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      valid_list_o[i] = (st_q[i] != E_FREE);
      if (st_q[i] == E_FREE) free_id = ENTRY_DEPTH'(i);
      if (st_q[i] == E_PEND) begin
        pend_id    = ENTRY_DEPTH'(i);
        pend_found = 1'b1;
      end
    end
  end

  assign full_o          = &valid_list_o;
  assign empty_o         = ~|valid_list_o;
  assign alloc_ready_o   = ~full_o;
  assign alloc_id_o      = free_id;
  assign mem_req_valid_o = lock_vld_q | pend_found;
  assign mem_req_id_o    = lock_vld_q ? lock_id_q : pend_id;
  assign mem_req_addr_o  = addr_q[mem_req_id_o];

  assign alloc_fire = alloc_valid_i & alloc_ready_o;
  assign issue_fire = mem_req_valid_o & mem_req_ready_i;
  // Only an ISSUED entry (pre-edge) can retire; same-cycle issue+response is dropped.
  assign retire     = mem_rsp_valid_i & (st_q[mem_rsp_id_i] == E_ISSUED);

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    if (issue_fire) begin
      lock_vld_d = 1'b0;
    end else if (mem_req_valid_o) begin
      lock_vld_d = 1'b1;
      lock_id_d  = mem_req_id_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        st_q[i]   <= E_FREE;
        addr_q[i] <= '0;
        wid_q[i]  <= '0;
      end
      lock_vld_q  <= 1'b0;
      lock_id_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_wid_q   <= '0;
    end else begin
      // Alloc, issue and retire always target entries in distinct states.
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (alloc_fire && free_id == ENTRY_DEPTH'(i)) begin
          st_q[i]   <= E_PEND;
          addr_q[i] <= alloc_addr_i;
          wid_q[i]  <= alloc_wid_i;
        end
        if (issue_fire && mem_req_id_o == ENTRY_DEPTH'(i)) st_q[i] <= E_ISSUED;
        if (retire && mem_rsp_id_i == ENTRY_DEPTH'(i)) st_q[i] <= E_FREE;
      end
      lock_vld_q  <= lock_vld_d;
      lock_id_q   <= lock_id_d;
      rsp_valid_q <= retire;
      if (retire) begin
        rsp_addr_q <= addr_q[mem_rsp_id_i];
        rsp_wid_q  <= wid_q[mem_rsp_id_i];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_wid_o   = rsp_wid_q;

endmodule
